pc_gen_unit: RTL
================

// Module: pc_gen_unit
// PURPOSE
//  Parametrised next-PC generator feeding the instruction-fetch stage; generalises the single
//  sequential/branch PC register to configurable width and step, with a fetch handshake,
//  prioritised redirect/trap sources, halt/resume control and misaligned-target detection.
//  Sits between the branch/exception logic and instruction memory.
// PARAMETERS
//  XLEN         64        PC width in bits
//  INSTR_BYTES  4         sequential increment; power of two; alignment = log2(INSTR_BYTES) LSBs
//  RESET_VECTOR 64'h0     PC value loaded by reset
//  TRAP_VECTOR  64'h100   PC value loaded on a trap or a misaligned redirect
//  RAS_DEPTH    4         return-address stack entries (used only with PCGEN_RAS_EN)
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  reset           in   1     asynchronous, active-high reset
//  fetch_ready     in   1     fetch stage accepts pc_out this cycle
//  fetch_valid     out  1     pc_out is a valid fetch address
//  pc_out          out  XLEN  current fetch PC
//  pc_plus         out  XLEN  pc_out + INSTR_BYTES (link value), combinational
//  redirect_valid  in   1     branch/jump resolved taken
//  redirect_target in   XLEN  branch/jump target
//  trap_req        in   1     exception/interrupt; load TRAP_VECTOR
//  halt_req        in   1     stop issuing fetches
//  resume          in   1     leave HALT
//  call_push       in   1     call retired: push call_ret_addr on RAS
//  call_ret_addr   in   XLEN  return address to push
//  ret_pop         in   1     return decoded: take predicted target from RAS
//  misalign_err    out  1     one-cycle pulse: redirect_target misaligned
//  state_o         out  2     FSM state (BOOT=0, RUN=1, HALT=2)
// BEHAVIOUR
//  - Reset (async): pc_out=RESET_VECTOR, fetch_valid=0, misalign_err=0, state=BOOT, RAS count=0.
//  - BOOT: fetch_valid=0 for exactly one cycle after reset deasserts; then RUN.
//  - RUN: fetch_valid=1. HALT: fetch_valid=0; pc_out held unless a source below fires.
//  - Next-PC priority at each edge (highest first):
//    1 trap_req -> TRAP_VECTOR; state->RUN (also from HALT).
//    2 redirect_valid, target aligned -> redirect_target; state unchanged.
//      redirect_valid, target[log2(INSTR_BYTES)-1:0]!=0 -> TRAP_VECTOR, misalign_err=1 next cycle.
//    3 ret_pop with RAS non-empty (RUN only) -> popped address.
//    4 RUN & fetch_valid & fetch_ready -> pc_out + INSTR_BYTES.
//    5 otherwise hold.
//  - Sequential increment wraps modulo 2^XLEN (all-ones - 3 -> 0 for step 4); no error.
//  - Redirect latency: 1 cycle; new pc_out visible the cycle after the input is sampled.
//  - halt_req in RUN -> HALT next edge (same-edge PC update still applies per priority);
//    resume in HALT -> RUN; halt_req and resume both high -> halt_req wins.
//  - Inputs ignored during BOOT except trap_req.
//  - Reset mid-operation: immediate return to reset values, RAS discarded.
// CONFIGURATION
//  PCGEN_RAS_EN defined: circular RAS of RAS_DEPTH entries.
//    push when full overwrites oldest; pop when empty falls through to priority 4;
//    push+pop same cycle: top read for next PC, then replaced by call_ret_addr (count unchanged).
//  PCGEN_RAS_EN undefined: no RAS storage; call_push/call_ret_addr/ret_pop present but ignored.
// STRUCTURE
//  pcgen_pkg: state enum (BOOT/RUN/HALT), ALIGN_BITS=$clog2(INSTR_BYTES) helper, priority constants.
//  Sub-module pcgen_ras (stack storage, pointer, count), instantiated only under PCGEN_RAS_EN.
// TESTING
//  1 reset high then low -> pc_out=0, fetch_valid=0 one cycle, then 1; with fetch_ready=1 PC 0,4,8,C.
//  2 fetch_ready=0 for 3 cycles at PC 8 -> pc_out stays 8; resume increment to C after.
//  3 redirect_valid, target 0x2000 with trap_req same cycle -> pc_out=0x100 next cycle.
//  4 redirect target 0x2002 -> pc_out=0x100, misalign_err=1 for exactly one cycle.
//  5 halt_req at PC 0x40 -> fetch_valid=0, PC held; resume -> PC advances 0x44; PC all-ones-3 wraps to 0.
//  6 (RAS_EN) push 0x10,0x20,0x30,0x40,0x50 then 5 pops -> targets 0x50,0x40,0x30,0x20, 5th pop sequential.

Source files
------------

// File: rtl/pc_gen_unit_pkg.sv
// Shared types for the next-PC generator: FSM states, next-PC source codes in priority order,
// and the alignment helper.
package pcgen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pcgen_state_e;

  // Listed from highest to lowest priority; SRC_MISALIGN shares the redirect slot.
  typedef enum logic [2:0] {
    SRC_TRAP     = 3'd0,
    SRC_MISALIGN = 3'd1,
    SRC_REDIRECT = 3'd2,
    SRC_RAS      = 3'd3,
    SRC_SEQ      = 3'd4,
    SRC_HOLD     = 3'd5
  } pcgen_src_e;

  function automatic int align_bits(input int instr_bytes);
    return (instr_bytes > 1) ? $clog2(instr_bytes) : 0;
  endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch/control bundle of the next-PC generator. The master modport is the generator side,
// and the slave modport is the branch, exception and fetch logic around it.
interface pc_gen_unit_if #(
  parameter int XLEN = 64
);
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_req;
  logic            halt_req;
  logic            resume;
  logic            call_push;
  logic [XLEN-1:0] call_ret_addr;
  logic            ret_pop;
  logic            misalign_err;
  logic [1:0]      state_o;

  modport master (
    input  fetch_ready, redirect_valid, redirect_target, trap_req, halt_req, resume,
           call_push, call_ret_addr, ret_pop,
    output fetch_valid, pc_out, pc_plus, misalign_err, state_o
  );

  modport slave (
    output fetch_ready, redirect_valid, redirect_target, trap_req, halt_req, resume,
           call_push, call_ret_addr, ret_pop,
    input  fetch_valid, pc_out, pc_plus, misalign_err, state_o
  );
endinterface

// File: rtl/pc_gen_unit_ras.sv
// Circular return-address stack. It overwrites the oldest entry on overflow. When a push and a
// pop occur together, the entry on top is replaced.
module pcgen_ras #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_addr_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  stack_q [DEPTH];
  logic [PTR_W-1:0] top_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
  endfunction

  assign pop_ok_s = pop_i && (count_q != '0);
  assign top_o    = stack_q[top_ptr_q];
  assign empty_o  = (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_ptr_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (push_i && pop_ok_s) begin
      stack_q[top_ptr_q] <= push_addr_i;
    end else if (push_i) begin
      stack_q[ptr_inc(top_ptr_q)] <= push_addr_i;
      top_ptr_q                   <= ptr_inc(top_ptr_q);
      if (count_q != CNT_W'(DEPTH)) begin
        count_q <= count_q + CNT_W'(1);
      end else begin
        count_q <= count_q;
      end
    end else if (pop_ok_s) begin
      top_ptr_q <= ptr_dec(top_ptr_q);
      count_q   <= count_q - CNT_W'(1);
    end else begin
      top_ptr_q <= top_ptr_q;
      count_q   <= count_q;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Next-PC generator for the fetch stage. It chooses between trap, redirect, return and
// sequential sources, and includes a BOOT/RUN/HALT control FSM. Define PCGEN_RAS_EN to build
// in the return-address stack.
module pc_gen_unit
  import pcgen_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(64'h100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  pc_gen_unit_if.master bus
);

  localparam int              ALIGN_BITS = align_bits(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  pcgen_state_e    state_q, state_d;
  pcgen_src_e      src_s;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus_s;
  logic            fetch_valid_q;
  logic            misalign_q, misalign_d;
  logic            redirect_misaligned_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_empty_s;

  assign pc_plus_s             = pc_q + XLEN'(INSTR_BYTES);
  assign redirect_misaligned_s = |(bus.redirect_target & ALIGN_MASK);

`ifdef PCGEN_RAS_EN
  logic ras_push_s;
  logic ras_pop_s;

  assign ras_push_s = bus.call_push && (state_q != ST_BOOT);
  assign ras_pop_s  = (src_s == SRC_RAS);

  pcgen_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push_s),
    .pop_i       (ras_pop_s),
    .push_addr_i (bus.call_ret_addr),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s)
  );
`else
  assign ras_top_s   = '0;
  assign ras_empty_s = 1'b1;
`endif

  always_comb begin
    src_s      = SRC_HOLD;
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (bus.trap_req) begin
          src_s = SRC_TRAP;
        end else begin
          src_s = SRC_HOLD;
        end
      end
      ST_RUN, ST_HALT: begin
        if (bus.trap_req) begin
          src_s = SRC_TRAP;
        end else if (bus.redirect_valid && redirect_misaligned_s) begin
          src_s = SRC_MISALIGN;
        end else if (bus.redirect_valid) begin
          src_s = SRC_REDIRECT;
        end else if ((state_q == ST_RUN) && bus.ret_pop && !ras_empty_s) begin
          src_s = SRC_RAS;
        end else if ((state_q == ST_RUN) && fetch_valid_q && bus.fetch_ready) begin
          src_s = SRC_SEQ;
        end else begin
          src_s = SRC_HOLD;
        end

        // A trap always resumes fetching. Otherwise halt_req beats resume.
        if (bus.trap_req) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && bus.halt_req) begin
          state_d = ST_HALT;
        end else if ((state_q == ST_HALT) && bus.resume && !bus.halt_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_BOOT;
        src_s   = SRC_HOLD;
      end
    endcase

    case (src_s)
      SRC_TRAP:     pc_d = TRAP_VECTOR;
      SRC_MISALIGN: begin
        pc_d       = TRAP_VECTOR;
        misalign_d = 1'b1;
      end
      SRC_REDIRECT: pc_d = bus.redirect_target;
      SRC_RAS:      pc_d = ras_top_s;
      SRC_SEQ:      pc_d = pc_plus_s;
      default:      pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= (state_d == ST_RUN);
      misalign_q    <= misalign_d;
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.pc_plus      = pc_plus_s;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.state_o      = state_q;

endmodule
